// File: rtl/masked_skid_buffer.sv
// Two-entry valid/ready skid buffer for a SHARES-way masked word; every share is a W-bit lane that is never combined with another share.
// Define MASKED_SKID_REFRESH_EN to re-mask each accepted word with rnd on entry; otherwise words pass bit-exact.
module masked_skid_buffer #(
  parameter int W      = 8,
  parameter int SHARES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SHARES*W-1:0]      in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [(SHARES-1)*W-1:0]  rnd,
  output logic [SHARES*W-1:0]      out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SHARES*W-1:0]   main_q, skid_q;
  logic [SHARES*W-1:0]   entry_word;
  logic                  in_fire, out_fire;
  logic                  main_load, main_from_skid, skid_load;

  // Outputs depend on state (and reset) only, so nothing upstream or downstream reaches them combinationally.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL) & ~rst;
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

`ifdef MASKED_SKID_REFRESH_EN
  logic [W-1:0] rnd_acc;

  // Shares 0..SHARES-2 absorb one random lane each; the last share absorbs all of them, so the unmasked value is preserved.
  always_comb begin
    entry_word = in_data;
    rnd_acc    = '0;
    for (int i = 0; i < SHARES-1; i++) begin
      entry_word[i*W +: W] = in_data[i*W +: W] ^ rnd[i*W +: W];
      rnd_acc              = rnd_acc ^ rnd[i*W +: W];
    end
    entry_word[(SHARES-1)*W +: W] = in_data[(SHARES-1)*W +: W] ^ rnd_acc;
  end
`else
  logic unused_rnd;

  assign entry_word = in_data;
  assign unused_rnd = ^rnd;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          main_load = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          skid_load = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // The skid word was refreshed when it entered; the move to main is a plain copy.
        if (out_fire) begin
          state_d        = ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: both data registers are reset to zero so a discarded word can never reappear after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_load) begin
        main_q <= main_from_skid ? skid_q : entry_word;
      end
      if (skid_load) begin
        skid_q <= entry_word;
      end
    end
  end

endmodule

// File: tb/tb_masked_skid_buffer.sv
// Scoreboard bench for masked_skid_buffer: driver pushes expected words on acceptance, monitor pops and compares.
// Honours MASKED_SKID_REFRESH_EN in its reference model.
module tb_masked_skid_buffer;

  localparam int W      = 8;
  localparam int SHARES = 2;
  localparam int DW     = SHARES*W;
  localparam int RW     = (SHARES-1)*W;

`ifdef MASKED_SKID_REFRESH_EN
  localparam logic [DW-1:0] REF_VEC_EXP = 16'h6699;
`else
  localparam logic [DW-1:0] REF_VEC_EXP = 16'h3CC3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] rnd = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_out = '0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  masked_skid_buffer #(.W(W), .SHARES(SHARES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rnd       (rnd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: unmasked value is kept, first shares get fresh lanes, last share closes the sum.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [RW-1:0] r);
    logic [W-1:0]  secret = '0;
    logic [W-1:0]  others = '0;
    logic [DW-1:0] res    = '0;
    for (int s = 0; s < SHARES; s++) secret ^= d[s*W +: W];
    for (int s = 0; s < SHARES-1; s++) begin
      res[s*W +: W] = d[s*W +: W] ^ r[s*W +: W];
      others       ^= res[s*W +: W];
    end
    res[(SHARES-1)*W +: W] = secret ^ others;
`ifdef MASKED_SKID_REFRESH_EN
    return res;
`else
    return (res == res) ? d : d;
`endif
  endfunction

  // One cycle of stimulus; acceptance is judged just before the sampling edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [RW-1:0] r,
                       input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    rnd       = r;
    out_ready = ordy;
    #2;
    acc = v && in_ready;
    if (acc) exp_q.push_back(model(d, r));
  endtask

  // Monitor: state-derived outputs vs model occupancy, data vs queue head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        check("reset out_valid", {15'd0, out_valid}, 16'd0);
        check("reset in_ready", {15'd0, in_ready}, 16'd0);
      end else begin
        check("out_valid", {15'd0, out_valid}, {15'd0, exp_q.size() > 0});
        check("in_ready", {15'd0, in_ready}, {15'd0, exp_q.size() < 2});
        if (out_valid && exp_q.size() > 0) begin
          check("out_data", out_data, exp_q[0]);
          if (out_ready) last_out = exp_q.pop_front();
        end else if (!out_valid) begin
          check("idle out_data held", out_data, last_out);
        end
      end
    end
  end

  initial begin
    logic acc;
    int   n;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Streaming at full rate.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, {8'(i + 1), 8'(i)}, RW'($urandom), 1'b1, acc);
      check("stream accept", {15'd0, acc}, 16'd1);
    end
    drive(1'b0, '0, '0, 1'b1, acc);
    drive(1'b0, '0, '0, 1'b1, acc);

    // Backpressure: one extra word, then refusal until FULL drains.
    drive(1'b1, 16'hAA55, RW'($urandom), 1'b0, acc);
    check("bp accept AA55", {15'd0, acc}, 16'd1);
    drive(1'b1, 16'h1234, RW'($urandom), 1'b0, acc);
    check("bp accept 1234", {15'd0, acc}, 16'd1);
    drive(1'b1, 16'h5678, RW'($urandom), 1'b0, acc);
    check("bp refuse 5678", {15'd0, acc}, 16'd0);
    drive(1'b1, 16'h5678, RW'($urandom), 1'b1, acc);
    check("full+out_ready refuse", {15'd0, acc}, 16'd0);
    drive(1'b1, 16'h5678, RW'($urandom), 1'b1, acc);
    check("bp accept 5678", {15'd0, acc}, 16'd1);
    repeat (3) drive(1'b0, '0, '0, 1'b1, acc);

    // Async reset while FULL discards both words.
    drive(1'b1, 16'hDEAD, RW'($urandom), 1'b0, acc);
    drive(1'b1, 16'hBEEF, RW'($urandom), 1'b0, acc);
    drive(1'b0, '0, '0, 1'b0, acc);
    #1;
    rst = 1'b1;
    exp_q.delete();
    last_out = '0;
    #1;
    check("async rst out_valid", {15'd0, out_valid}, 16'd0);
    check("async rst in_ready", {15'd0, in_ready}, 16'd0);
    check("async rst out_data", out_data, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) drive(1'b0, '0, '0, 1'b1, acc);

    // Refresh vector.
    drive(1'b1, 16'h3CC3, 8'h5A, 1'b0, acc);
    check("refresh accept", {15'd0, acc}, 16'd1);
    drive(1'b0, '0, '0, 1'b0, acc);
    check("refresh vector", out_data, REF_VEC_EXP);
    check("unmasked preserved", {8'd0, out_data[15:8] ^ out_data[7:0]}, 16'h00FF);
    drive(1'b0, '0, '0, 1'b1, acc);

    // Randomized traffic.
    repeat (600) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), RW'($urandom),
            ($urandom_range(0, 3) != 0), acc);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      drive(1'b0, '0, '0, 1'b1, acc);
      n++;
    end
    check("drain empty", 16'(exp_q.size()), 16'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
